// File: rtl/sram_resp_pkg.sv
// Shared state encoding and constants for the SRAM pin responder.
package sram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Pin address change to data on the pins, in clocks.
  localparam int RD_LATENCY = 3;
  localparam int CNT_WIDTH  = 32;

endpackage

// File: rtl/sram_resp_mem.sv
// Single-port block RAM with synchronous read; a write returns the new word
// on the read port in the same clock (write-first).
module sram_resp_mem #(
  parameter int pDATA_WIDTH     = 8,
  parameter int pMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [pMEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [pDATA_WIDTH-1:0]     wdata_i,
  output logic [pDATA_WIDTH-1:0]     rdata_o
);

  localparam int DEPTH = 1 << pMEM_ADDR_WIDTH;

  logic [pDATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Emulates an asynchronous SRAM on the board pins using block RAM behind a
// registered pin interface. Define SRAM_RESP_FAULT_EN to add read-fault injection.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int pDATA_WIDTH     = 8,
  parameter int pADDR_WIDTH     = 20,
  parameter int pMEM_ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cen,
  input  logic                   ce2,
  input  logic                   wen,
  input  logic                   oen,
  input  logic [pADDR_WIDTH-1:0] addr,
  inout  wire  [pDATA_WIDTH-1:0] data,
  output logic [CNT_WIDTH-1:0]   write_count,
  output logic [CNT_WIDTH-1:0]   read_count,
  output logic                   contention
`ifdef SRAM_RESP_FAULT_EN
  ,
  input  logic                       fault_en,
  input  logic [pMEM_ADDR_WIDTH-1:0] fault_addr
`endif
);

  logic                       s_cen_q, s_ce2_q, s_wen_q, s_oen_q;
  logic [pADDR_WIDTH-1:0]     s_addr_q, prev_addr_q;
  logic [pDATA_WIDTH-1:0]     s_data_q;
  state_e                     state_q, state_d;
  logic [pMEM_ADDR_WIDTH-1:0] hold_addr_q, mem_addr;
  logic [pDATA_WIDTH-1:0]     hold_data_q, mem_rdata, dout_q, dout_d;
  logic [CNT_WIDTH-1:0]       write_count_q, read_count_q;
  logic                       contention_q, drive_q;
  logic                       sel, wr_req, rd_req, commit, rd_access;

  // Strobes reset to their inactive levels so nothing looks selected after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_cen_q  <= 1'b1;
      s_ce2_q  <= 1'b0;
      s_wen_q  <= 1'b1;
      s_oen_q  <= 1'b1;
      s_addr_q <= '0;
      s_data_q <= '0;
    end else begin
      s_cen_q  <= cen;
      s_ce2_q  <= ce2;
      s_wen_q  <= wen;
      s_oen_q  <= oen;
      s_addr_q <= addr;
      s_data_q <= data;
    end
  end

  assign sel    = ~s_cen_q & s_ce2_q;
  assign wr_req = sel & ~s_wen_q;
  assign rd_req = sel & s_wen_q & ~s_oen_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Every exit re-applies the IDLE entry rules, so write always wins over read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wr_req) state_d = WRITE; else if (rd_req) state_d = READ;
      WRITE:   if (!wr_req) state_d = rd_req ? READ : IDLE;
      READ:    if (!rd_req) state_d = wr_req ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    commit    = (state_q == WRITE) && !wr_req && !reset;
    rd_access = (state_d == READ) && ((state_q != READ) || (s_addr_q != prev_addr_q));
    mem_addr  = commit ? hold_addr_q : s_addr_q[pMEM_ADDR_WIDTH-1:0];
  end

  sram_resp_mem #(
    .pDATA_WIDTH    (pDATA_WIDTH),
    .pMEM_ADDR_WIDTH(pMEM_ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (commit),
    .addr_i (mem_addr),
    .wdata_i(hold_data_q),
    .rdata_o(mem_rdata)
  );

`ifdef SRAM_RESP_FAULT_EN
  logic [pMEM_ADDR_WIDTH-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    rd_addr_q <= mem_addr;
  end

  assign dout_d = mem_rdata ^ {{(pDATA_WIDTH-1){1'b0}}, (fault_en && (rd_addr_q == fault_addr))};
`else
  assign dout_d = mem_rdata;
`endif

  // Drive follows the read state with no pipeline wait, so it drops two clocks after the pins leave READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_count_q <= '0;
      read_count_q  <= '0;
      contention_q  <= 1'b0;
      drive_q       <= 1'b0;
    end else begin
      if (commit)             write_count_q <= write_count_q + CNT_WIDTH'(1);
      if (rd_access)          read_count_q  <= read_count_q + CNT_WIDTH'(1);
      if (wr_req && !s_oen_q) contention_q  <= 1'b1;
      drive_q <= (state_q == READ) && (state_d == READ);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_req) begin
      hold_addr_q <= s_addr_q[pMEM_ADDR_WIDTH-1:0];
      hold_data_q <= s_data_q;
    end
    prev_addr_q <= s_addr_q;
    dout_q      <= dout_d;
  end

  assign data        = drive_q ? dout_q : {pDATA_WIDTH{1'bz}};
  assign write_count = write_count_q;
  assign read_count  = read_count_q;
  assign contention  = contention_q;

endmodule
